// File: rtl/edid_reader.sv
// rtl/edid_reader.sv - I2C master that reads a 128-byte EDID block into a local buffer
module edid_reader #(
  parameter int unsigned CLK_DIV  = 50,
  parameter logic [6:0]  DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       chksum_ok,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE, START, WR_BYTE, WR_ACK, RSTART, RD_BYTE, RD_ACK, STOP
  } state_t;

  localparam logic [9:0] DIV_MAX = 10'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [9:0] div_q, div_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [6:0] byte_q, byte_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] phase_q, phase_d;   // which write byte: 0 addr+W, 1 word addr, 2 addr+R
  logic       nack_q, nack_d;
  logic [7:0] sum_q, sum_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       chksum_ok_q, chksum_ok_d;
  logic       edid_we;
  logic       scl_pull, sda_pull;
  logic       tick, sample, slot_end;
  logic [7:0] edid_q [128];
  logic [7:0] rd_data_q;

  assign tick     = (state_q != IDLE) && (div_q == DIV_MAX);
  assign sample   = tick && (qtr_q == 2'd2);
  assign slot_end = tick && (qtr_q == 2'd3);

  // Next-state, quarter timing and open-drain line drive
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    nack_d      = nack_q;
    sum_d       = sum_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;
    chksum_ok_d = chksum_ok_q;
    edid_we     = 1'b0;
    scl_pull    = 1'b0;
    sda_pull    = 1'b0;
    if (state_q != IDLE) begin
      div_d = tick ? 10'd0 : div_q + 10'd1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = START;
          sum_d       = 8'd0;
          ack_err_d   = 1'b0;
          chksum_ok_d = 1'b0;
          bit_d       = 3'd0;
          byte_d      = 7'd0;
          phase_d     = 2'd0;
        end
      end
      START: begin
        sda_pull = (qtr_q >= 2'd2);
        scl_pull = (qtr_q == 2'd3);
        if (slot_end) begin
          state_d = WR_BYTE;
          shift_d = {DEV_ADDR, 1'b0};
          phase_d = 2'd0;
        end
      end
      WR_BYTE: begin
        scl_pull = (qtr_q < 2'd2);
        sda_pull = ~shift_q[7];
        if (slot_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        scl_pull = (qtr_q < 2'd2);
        if (sample) nack_d = sda_i;
        if (slot_end) begin
          if (nack_q) begin
            state_d   = STOP;
            ack_err_d = 1'b1;
          end else if (phase_q == 2'd0) begin
            state_d = WR_BYTE;
            shift_d = 8'h00;
            phase_d = 2'd1;
          end else if (phase_q == 2'd1) begin
            state_d = RSTART;
          end else begin
            state_d = RD_BYTE;
            byte_d  = 7'd0;
          end
        end
      end
      RSTART: begin
        // SCL low first so the slave drops its ACK before SDA rises under a high SCL
        scl_pull = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_pull = (qtr_q >= 2'd2);
        if (slot_end) begin
          state_d = WR_BYTE;
          shift_d = {DEV_ADDR, 1'b1};
          phase_d = 2'd2;
        end
      end
      RD_BYTE: begin
        scl_pull = (qtr_q < 2'd2);
        if (sample) shift_d = {shift_q[6:0], sda_i};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            edid_we = 1'b1;
            sum_d   = sum_q + shift_q;
            state_d = RD_ACK;
          end
        end
      end
      RD_ACK: begin
        scl_pull = (qtr_q < 2'd2);
        sda_pull = (byte_q != 7'd127);
        if (slot_end) begin
          if (byte_q == 7'd127) begin
            state_d = STOP;
          end else begin
            byte_d  = byte_q + 7'd1;
            state_d = RD_BYTE;
          end
        end
      end
      STOP: begin
        // SCL is released from Q1 so the SDA release at Q2 happens with SCL already high
        scl_pull = (qtr_q == 2'd0);
        sda_pull = (qtr_q < 2'd2);
        if (slot_end) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          chksum_ok_d = ~ack_err_q && (sum_q == 8'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register; reset drops the FSM to IDLE, which releases both lines at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      phase_q     <= '0;
      nack_q      <= 1'b0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      chksum_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      nack_q      <= nack_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      chksum_ok_q <= chksum_ok_d;
    end
  end

  // EDID buffer: not reset, read port returns the pre-write value on a same-address collision
  always_ff @(posedge clk) begin
    if (edid_we) edid_q[byte_q] <= shift_q;
    rd_data_q <= edid_q[rd_addr];
  end

  assign scl_oe    = scl_pull;
  assign sda_oe    = sda_pull;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign chksum_ok = chksum_ok_q;
  assign rd_data   = rd_data_q;

endmodule
